ram_bus_master: RTL and testbench
=================================

# ram_bus_master

Command-driven bus initiator for the 128 x 8 sound-board scratch RAM. It accepts single-byte read/write, block-fill and block-copy commands over a valid/ready handshake. It sequences the matching chip-select, read/write, address and write-data cycles on the RAM port, then reports read data and command completion. It sits between the sound-board control logic (or a self-test/clear sequencer) and the RAM, as the initiating end of that RAM's bus.

## Interface
Parameters:
- ADDR_W, 7, RAM address width (128 locations)
- DATA_W, 8, RAM data width

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
  - clk  in  1  system clock
  - rst  in  1  asynchronous, active-high reset
- Command channel:
  - cmd_valid  in  1  command present
  - cmd_ready  out  1  block can accept a command
  - cmd_op  in  2  0=READ, 1=WRITE, 2=FILL, 3=COPY
  - cmd_addr  in  7  target/destination start address
  - cmd_src  in  7  COPY source start address (ignored otherwise)
  - cmd_len  in  8  FILL/COPY byte count, 0..255 (ignored for READ/WRITE)
  - cmd_data  in  8  WRITE/FILL data
- Response:
  - rsp_valid  out  1  one-cycle pulse, rsp_data valid (READ only)
  - rsp_data  out  8  captured read byte
  - done  out  1  one-cycle pulse on command completion
  - busy  out  1  high from acceptance through the done cycle
- RAM port:
  - ram_cs  out  1  RAM chip select
  - ram_rw  out  1  1=read, 0=write
  - ram_addr  out  7  RAM address
  - ram_wdata  out  8  RAM write data
  - ram_rdata  in  8  RAM read data, combinational from ram_addr

## Operation
- The RAM writes on the clk edge when ram_cs=1 and ram_rw=0.
- RAM read data is combinational from ram_addr and is captured on the edge ending the read cycle.
- States:
  - IDLE: cmd_ready=1; accepts on cmd_valid && cmd_ready.
  - READ → DONE
  - WRITE → DONE
  - FILL: loops until count exhausted → DONE
  - COPY_RD ⇄ COPY_WR: loops until count exhausted → DONE
  - DONE → IDLE
- A command with cmd_len=0 for FILL/COPY goes straight to DONE with no bus cycles.
- Command fields are latched at acceptance; later input changes have no effect.
- Each bus cycle is one clk cycle:
  - READ: cs=1, rw=1, addr=cmd_addr.
  - WRITE: cs=1, rw=0, addr=cmd_addr, wdata=cmd_data.
  - FILL: one write per cycle at cmd_addr+i, i=0..len-1.
  - COPY: read at src+i, holding register captures the byte, then write at dst+i. Two cycles per byte, ascending order.
- Address arithmetic is modulo 128. Addresses wrap 127→0, and len>128 revisits locations.
- Overlapping COPY is strictly forward byte order. With dst>src the source pattern propagates; this is specified, not an error.
- Outside bus cycles: ram_cs=0, ram_rw=1, ram_addr and ram_wdata hold their last values.
- Reset values:
  - State is IDLE and cmd_ready=1.
  - rsp_valid, done, busy and ram_cs are 0.
  - ram_rw is 1.
  - ram_addr, ram_wdata and rsp_data are 0.
- Reset mid-command aborts immediately, with no further RAM cycles. Partially written data stays in the RAM.

## Timing
- All outputs are registered except cmd_ready (= state IDLE).
- Acceptance edge is T0, and the first bus cycle is T0+1.
- Completion and latency:
  - READ: rsp_valid and done at T0+2, with rsp_data held until the next READ.
  - WRITE: done at T0+2.
  - FILL N: done at T0+N+1.
  - COPY N: done at T0+2N+1.
  - Length 0: done at T0+1.
- cmd_ready is 0 from T0+1 through the done cycle. The next command can be accepted the cycle after done, so back-to-back READs are 3 cycles apart.
- No backpressure on rsp_valid/done.

## Structure
- Shared package ram_bus_pkg holds:
  - op encoding constants: OP_READ, OP_WRITE, OP_FILL, OP_COPY
  - state enum
  - ADDR_W/DATA_W defaults
- One natural sub-module, ram_bus_addr_gen: src/dst pointers with modulo-128 increment, and a byte down-counter with zero flag.

## Test plan
- WRITE 0x5A to 0x10, then READ 0x10 → done at T0+2 for each; rsp_valid with rsp_data=0x5A at T0+2 of the READ.
- FILL addr=0x7E len=4 data=0xA5 → writes to 0x7E, 0x7F, 0x00, 0x01 on consecutive cycles; done at T0+5; 0x7D and 0x02 unchanged.
- Preload 0x20..0x23 = 1,2,3,4, then COPY src=0x20 dst=0x40 len=4 → 0x40..0x43 = 1,2,3,4; ram_cs toggles rw=1/0 for 8 cycles; done at T0+9.
- Overlap COPY src=0x00 dst=0x01 len=3 with 0x00=0x11 → 0x01..0x03 all 0x11. Separately, FILL len=0 → done at T0+1 with no ram_cs.
- Assert rst at the third cycle of FILL len=10 → ram_cs=0, cmd_ready=1 and busy=0 immediately; only the first two locations are written. cmd_valid held during busy is not accepted until after done.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the scratch-RAM bus initiator: command opcodes,
// sequencer states and default bus geometry.
package ram_bus_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int LEN_W      = 8;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_COPY  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_bus_addr_gen.sv
// Source/destination pointers (wrapping at the address width) and the
// remaining-byte down-counter for block commands.
module ram_bus_addr_gen
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_init,
  input  logic [ADDR_W-1:0] dst_init,
  input  logic [LEN_W-1:0]  cnt_init,
  input  logic              step_src,
  input  logic              step_dst,
  input  logic              dec,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              cnt_zero
);

  logic [LEN_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
    end else if (load) begin
      src_ptr <= src_init;
      dst_ptr <= dst_init;
      cnt     <= cnt_init;
    end else begin
      if (step_src) src_ptr <= src_ptr + 1'b1;
      if (step_dst) dst_ptr <= dst_ptr + 1'b1;
      if (dec)      cnt     <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Command-driven initiator for the 128 x 8 scratch RAM: single read/write,
// block fill and forward block copy, with registered bus and response outputs.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state, state_d;
  logic              cs_d, rw_d, done_d, rsp_valid_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rsp_data_d;
  logic              load, step_src, step_dst, dec, cnt_zero;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, src_init, dst_init;
  logic [LEN_W-1:0]  cnt_init;

  // The first bus cycle is issued straight from the command fields, so the
  // pointers load one step ahead and the counter tracks writes still to issue.
  assign src_init  = cmd_src + 1'b1;
  assign dst_init  = (cmd_op == OP_COPY) ? cmd_addr : cmd_addr + 1'b1;
  assign cnt_init  = (cmd_op == OP_FILL) ? cmd_len - 1'b1 : cmd_len;
  assign cmd_ready = (state == ST_IDLE);

  ram_bus_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .src_init (src_init),
    .dst_init (dst_init),
    .cnt_init (cnt_init),
    .step_src (step_src),
    .step_dst (step_dst),
    .dec      (dec),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    cs_d        = 1'b0;
    rw_d        = 1'b1;
    addr_d      = ram_addr;
    wdata_d     = ram_wdata;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    load        = 1'b0;
    step_src    = 1'b0;
    step_dst    = 1'b0;
    dec         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          load = 1'b1;
          case (cmd_op)
            OP_READ: begin
              state_d = ST_READ;
              cs_d    = 1'b1;
              addr_d  = cmd_addr;
            end
            OP_WRITE: begin
              state_d = ST_WRITE;
              cs_d    = 1'b1;
              rw_d    = 1'b0;
              addr_d  = cmd_addr;
              wdata_d = cmd_data;
            end
            OP_FILL: begin
              if (cmd_len == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_FILL;
                cs_d    = 1'b1;
                rw_d    = 1'b0;
                addr_d  = cmd_addr;
                wdata_d = cmd_data;
              end
            end
            default: begin
              if (cmd_len == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_COPY_RD;
                cs_d    = 1'b1;
                addr_d  = cmd_src;
              end
            end
          endcase
        end
      end
      ST_READ: begin
        state_d     = ST_DONE;
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
        done_d      = 1'b1;
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_FILL: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cs_d     = 1'b1;
          rw_d     = 1'b0;
          addr_d   = dst_ptr;
          step_dst = 1'b1;
          dec      = 1'b1;
        end
      end
      ST_COPY_RD: begin
        // ram_wdata doubles as the copy holding register.
        state_d  = ST_COPY_WR;
        cs_d     = 1'b1;
        rw_d     = 1'b0;
        addr_d   = dst_ptr;
        wdata_d  = ram_rdata;
        step_dst = 1'b1;
        dec      = 1'b1;
      end
      ST_COPY_WR: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_COPY_RD;
          cs_d     = 1'b1;
          addr_d   = src_ptr;
          step_src = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cs    <= 1'b0;
      ram_rw    <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_cs    <= cs_d;
      ram_rw    <= rw_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      done      <= done_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural 128 x 8 RAM and a
// log of every bus cycle the initiator drives.
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_addr, cmd_src;
  logic [7:0] cmd_len, cmd_data;
  logic       rsp_valid, done, busy;
  logic [7:0] rsp_data;
  logic       ram_cs, ram_rw;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  logic [7:0] mem [128];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       last_rv;
  logic [7:0] last_rd;
  bit         busy_ok;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } bus_t;
  bus_t bus_log[$];

  ram_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_src   (cmd_src),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .done      (done),
    .busy      (busy),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_cs) begin
      bus_log.push_back('{rw: ram_rw, addr: ram_addr, wdata: ram_wdata, cyc: cyc});
      if (!ram_rw) mem[ram_addr] = ram_wdata;
    end
  end

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (!busy || cmd_ready) busy_ok = 1'b0;
      if (done) begin
        lat     = k;
        last_rv = rsp_valid;
        last_rd = rsp_data;
        break;
      end
    end
  endtask

  // Fields are scrambled right after acceptance to show they were latched.
  task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [6:0] src,
                       input logic [7:0] len, input logic [7:0] data, output int lat);
    bus_log.delete();
    busy_ok = 1'b1;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_src = src; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_addr = ~addr; cmd_src = ~src; cmd_len = ~len; cmd_data = ~data;
    wait_done(lat);
  endtask

  task automatic test_reset();
    logic [7:0] got [9];
    logic [7:0] exp [9];
    string      nm  [9];
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_src = '0;
    cmd_len = '0; cmd_data = '0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    #12;
    got = '{8'(cmd_ready), 8'(rsp_valid), 8'(done), 8'(busy), 8'(ram_cs), 8'(ram_rw),
            8'(ram_addr), ram_wdata, rsp_data};
    exp = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    nm  = '{"cmd_ready", "rsp_valid", "done", "busy", "ram_cs", "ram_rw", "ram_addr",
            "ram_wdata", "rsp_data"};
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        $display("FAIL reset_%s: got %h expected %h", nm[i], got[i], exp[i]); n_fail++;
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    issue(OP_WRITE, 7'h10, 7'h00, 8'd0, 8'h5A, lat);
    n_tests++;
    if (lat !== 2) begin $display("FAIL write_latency: got %0d expected 2", lat); n_fail++; end
    n_tests++;
    if (bus_log.size() != 1 || bus_log[0].rw !== 1'b0 || bus_log[0].addr !== 7'h10 ||
        bus_log[0].wdata !== 8'h5A) begin
      $display("FAIL write_bus: %0d cycles, expected one write of 5a to 10", bus_log.size());
      n_fail++;
    end
    n_tests++;
    if (!busy_ok) begin $display("FAIL write_busy: busy/cmd_ready wrong while active"); n_fail++; end
    issue(OP_READ, 7'h10, 7'h00, 8'd0, 8'h00, lat);
    n_tests++;
    if (lat !== 2) begin $display("FAIL read_latency: got %0d expected 2", lat); n_fail++; end
    n_tests++;
    if (last_rv !== 1'b1 || last_rd !== 8'h5A) begin
      $display("FAIL read_rsp: got valid=%b data=%h expected valid=1 data=5a", last_rv, last_rd);
      n_fail++;
    end
    n_tests++;
    if (bus_log.size() != 1 || bus_log[0].rw !== 1'b1 || bus_log[0].addr !== 7'h10) begin
      $display("FAIL read_bus: %0d cycles, expected one read of 10", bus_log.size()); n_fail++;
    end
  endtask

  task automatic test_fill_wrap();
    int         lat;
    logic [6:0] ea;
    mem[7'h7D] = 8'hEE; mem[7'h02] = 8'hEE;
    issue(OP_FILL, 7'h7E, 7'h00, 8'd4, 8'hA5, lat);
    n_tests++;
    if (lat !== 5) begin $display("FAIL fill_latency: got %0d expected 5", lat); n_fail++; end
    n_tests++;
    if (bus_log.size() != 4) begin
      $display("FAIL fill_cycles: got %0d expected 4", bus_log.size()); n_fail++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ea = 7'(7'h7E + i);
        n_tests++;
        if (bus_log[i].rw !== 1'b0 || bus_log[i].addr !== ea || bus_log[i].wdata !== 8'hA5 ||
            bus_log[i].cyc != bus_log[0].cyc + i) begin
          $display("FAIL fill_cycle%0d: got rw=%b addr=%h data=%h expected rw=0 addr=%h data=a5",
                   i, bus_log[i].rw, bus_log[i].addr, bus_log[i].wdata, ea);
          n_fail++;
        end
      end
    end
    n_tests++;
    if (mem[7'h7E] !== 8'hA5 || mem[7'h7F] !== 8'hA5 || mem[7'h00] !== 8'hA5 ||
        mem[7'h01] !== 8'hA5 || mem[7'h7D] !== 8'hEE || mem[7'h02] !== 8'hEE) begin
      $display("FAIL fill_mem: got 7d..02 = %h %h %h %h %h %h expected ee a5 a5 a5 a5 ee",
               mem[7'h7D], mem[7'h7E], mem[7'h7F], mem[7'h00], mem[7'h01], mem[7'h02]);
      n_fail++;
    end
    n_tests++;
    if (last_rv !== 1'b0 || last_rd !== 8'h5A) begin
      $display("FAIL fill_rsp_hold: got valid=%b data=%h expected valid=0 data=5a",
               last_rv, last_rd);
      n_fail++;
    end
  endtask

  task automatic test_copy();
    int         lat;
    logic [6:0] ea;
    for (int i = 0; i < 4; i++) mem[7'h20 + i] = 8'(i + 1);
    issue(OP_COPY, 7'h40, 7'h20, 8'd4, 8'h00, lat);
    n_tests++;
    if (lat !== 9) begin $display("FAIL copy_latency: got %0d expected 9", lat); n_fail++; end
    n_tests++;
    if (bus_log.size() != 8) begin
      $display("FAIL copy_cycles: got %0d expected 8", bus_log.size()); n_fail++;
    end else begin
      for (int j = 0; j < 8; j++) begin
        ea = (j % 2 == 0) ? 7'(7'h20 + j / 2) : 7'(7'h40 + j / 2);
        n_tests++;
        if (bus_log[j].rw !== ((j % 2) == 0) || bus_log[j].addr !== ea ||
            bus_log[j].cyc != bus_log[0].cyc + j) begin
          $display("FAIL copy_cycle%0d: got rw=%b addr=%h expected rw=%0d addr=%h",
                   j, bus_log[j].rw, bus_log[j].addr, (j % 2) == 0, ea);
          n_fail++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[7'h40 + i] !== 8'(i + 1)) begin
        $display("FAIL copy_mem%0d: got %h expected %h", i, mem[7'h40 + i], 8'(i + 1));
        n_fail++;
      end
    end
  endtask

  task automatic test_copy_overlap();
    int lat;
    mem[0] = 8'h11; mem[1] = 8'hB1; mem[2] = 8'hB2; mem[3] = 8'hB3; mem[4] = 8'hC4;
    issue(OP_COPY, 7'h01, 7'h00, 8'd3, 8'h00, lat);
    n_tests++;
    if (lat !== 7) begin $display("FAIL overlap_latency: got %0d expected 7", lat); n_fail++; end
    n_tests++;
    if (mem[1] !== 8'h11 || mem[2] !== 8'h11 || mem[3] !== 8'h11 || mem[4] !== 8'hC4) begin
      $display("FAIL overlap_mem: got 01..04 = %h %h %h %h expected 11 11 11 c4",
               mem[1], mem[2], mem[3], mem[4]);
      n_fail++;
    end
  endtask

  task automatic test_len_zero();
    int lat;
    issue(OP_FILL, 7'h30, 7'h00, 8'd0, 8'h99, lat);
    n_tests++;
    if (lat !== 1 || bus_log.size() != 0) begin
      $display("FAIL fill0: got latency %0d with %0d cycles expected 1 with 0", lat,
               bus_log.size());
      n_fail++;
    end
    issue(OP_COPY, 7'h31, 7'h30, 8'd0, 8'h00, lat);
    n_tests++;
    if (lat !== 1 || bus_log.size() != 0) begin
      $display("FAIL copy0: got latency %0d with %0d cycles expected 1 with 0", lat,
               bus_log.size());
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [7:0] rd1;
    bus_log.delete();
    busy_ok = 1'b1;
    @(negedge clk);
    cmd_op = OP_READ; cmd_addr = 7'h40; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_addr = 7'h41;
    wait_done(lat1);
    rd1 = last_rd;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(lat2);
    n_tests++;
    if (lat1 !== 2 || lat2 !== 2 || rd1 !== 8'h01 || last_rd !== 8'h02) begin
      $display("FAIL b2b_reads: got lat %0d/%0d data %h/%h expected 2/2 01/02",
               lat1, lat2, rd1, last_rd);
      n_fail++;
    end
    n_tests++;
    if (bus_log.size() != 2 || bus_log[1].cyc - bus_log[0].cyc != 3) begin
      $display("FAIL b2b_spacing: got %0d cycles expected 2 reads 3 cycles apart",
               bus_log.size());
      n_fail++;
    end
  endtask

  task automatic test_busy_hold();
    int lat1, lat2;
    bus_log.delete();
    busy_ok = 1'b1;
    @(negedge clk);
    cmd_op = OP_FILL; cmd_addr = 7'h60; cmd_len = 8'd3; cmd_data = 8'h33; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = OP_WRITE; cmd_addr = 7'h70; cmd_data = 8'h44;
    wait_done(lat1);
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(lat2);
    n_tests++;
    if (lat1 !== 4 || lat2 !== 2 || !busy_ok) begin
      $display("FAIL hold_latency: got %0d/%0d busy_ok=%b expected 4/2 busy_ok=1",
               lat1, lat2, busy_ok);
      n_fail++;
    end
    n_tests++;
    if (bus_log.size() != 4 || bus_log[2].addr !== 7'h62 || bus_log[3].addr !== 7'h70 ||
        bus_log[3].wdata !== 8'h44 || bus_log[3].cyc != bus_log[0].cyc + 5 ||
        mem[7'h70] !== 8'h44) begin
      $display("FAIL hold_accept: got %0d cycles mem70=%h expected fill 60..62 then write 44 at 70",
               bus_log.size(), mem[7'h70]);
      n_fail++;
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 4; i++) mem[7'h50 + i] = 8'h00;
    bus_log.delete();
    @(negedge clk);
    cmd_op = OP_FILL; cmd_addr = 7'h50; cmd_len = 8'd10; cmd_data = 8'h77; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (ram_cs !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL abort_outputs: got cs=%b ready=%b busy=%b expected 0 1 0",
               ram_cs, cmd_ready, busy);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[7'h50] !== 8'h77 || mem[7'h51] !== 8'h77 || mem[7'h52] !== 8'h00 ||
        mem[7'h53] !== 8'h00 || bus_log.size() != 2) begin
      $display("FAIL abort_mem: got 50..53 = %h %h %h %h after %0d cycles expected 77 77 00 00 after 2",
               mem[7'h50], mem[7'h51], mem[7'h52], mem[7'h53], bus_log.size());
      n_fail++;
    end
    n_tests++;
    if (ram_rw !== 1'b1 || ram_addr !== 7'h00 || rsp_data !== 8'h00 || done !== 1'b0) begin
      $display("FAIL abort_idle: got rw=%b addr=%h rsp=%h done=%b expected 1 00 00 0",
               ram_rw, ram_addr, rsp_data, done);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill_wrap();
    test_copy();
    test_copy_overlap();
    test_len_zero();
    test_back_to_back();
    test_busy_hold();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
